// File: rtl/gauss_filter_imgrd.sv
// Read-address generator for a separable 5-tap Gaussian: a row pass over the source image,
// then a transposed column pass over the intermediate, with edge pixels replicated by clamping.
module gauss_filter_imgrd #(
    parameter int IMG_W = 256,
    parameter int PAD   = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       hold_i,
    output logic       busy_o,
    output logic       finish,
    output logic       rd_en_o,
    output logic       rd_sel_o,
    output logic [7:0] rd_px_o,
    output logic [7:0] rd_py_o,
    input  logic [7:0] rd_dt_i,
    output logic [7:0] dt_o,
    output logic       dv_o
);

    localparam logic signed [9:0] INNER_FIRST = 10'(-PAD);
    localparam logic signed [9:0] INNER_LAST  = 10'(IMG_W - 1 + PAD);
    localparam logic signed [9:0] OUTER_LAST  = 10'(IMG_W - 1);

    typedef enum logic [1:0] {IDLE, SCAN, DRAIN} state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic               r_step;
    logic signed [9:0]  r_outer;
    logic signed [9:0]  r_inner;
    logic [1:0]         r_drain_cnt;
    logic               r_en_p1;

    logic               w_issue;
    logic               w_last;
    logic               w_step_nxt;
    logic signed [9:0]  w_outer_nxt;
    logic signed [9:0]  w_inner_nxt;
    logic [7:0]         w_clamped;

    function automatic logic [7:0] clamp_coord(input logic signed [9:0] v);
        if (v < 10'sd0)
            return 8'd0;
        else if (v > OUTER_LAST)
            return 8'(IMG_W - 1);
        else
            return v[7:0];
    endfunction

    assign w_clamped = clamp_coord(r_inner);
    assign w_last    = r_step && (r_outer == OUTER_LAST) && (r_inner == INNER_LAST);
    assign busy_o    = (r_state != IDLE);
    // Completion coincides with the last pixel leaving the two-cycle data pipe.
    assign finish    = (r_state == DRAIN) && (r_drain_cnt == 2'd2);

    always_comb begin
        w_step_nxt  = r_step;
        w_outer_nxt = r_outer;
        w_inner_nxt = r_inner + 10'sd1;
        if (r_inner == INNER_LAST) begin
            w_inner_nxt = INNER_FIRST;
            if (r_outer == OUTER_LAST) begin
                w_outer_nxt = 10'sd0;
                w_step_nxt  = ~r_step;
            end else begin
                w_outer_nxt = r_outer + 10'sd1;
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_issue     = 1'b0;
        case (r_state)
            IDLE: begin
                if (start)
                    w_state_nxt = SCAN;
            end
            SCAN: begin
                if (start) begin
                    w_state_nxt = SCAN;
                end else if (!hold_i) begin
                    w_issue = 1'b1;
                    if (w_last)
                        w_state_nxt = DRAIN;
                end
            end
            DRAIN: begin
                if (start)
                    w_state_nxt = SCAN;
                else if (r_drain_cnt == 2'd2)
                    w_state_nxt = IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_step      <= 1'b0;
            r_outer     <= 10'sd0;
            r_inner     <= INNER_FIRST;
            r_drain_cnt <= 2'd0;
            rd_en_o     <= 1'b0;
            rd_sel_o    <= 1'b0;
            rd_px_o     <= 8'd0;
            rd_py_o     <= 8'd0;
            r_en_p1     <= 1'b0;
            dv_o        <= 1'b0;
            dt_o        <= 8'd0;
        end else begin
            r_state     <= w_state_nxt;
            r_drain_cnt <= (r_state == DRAIN) ? r_drain_cnt + 2'd1 : 2'd0;
            // Data pipe stage p1: memory returns the pixel one cycle after the strobe.
            r_en_p1     <= rd_en_o;
            // Output stage: registered pixel to the filter.
            dv_o        <= r_en_p1;
            dt_o        <= rd_dt_i;
            if (start) begin
                // (Re)launch: issue the first read now and discard anything still in flight.
                rd_en_o     <= 1'b1;
                rd_sel_o    <= 1'b0;
                rd_px_o     <= 8'd0;
                rd_py_o     <= 8'd0;
                r_step      <= 1'b0;
                r_outer     <= 10'sd0;
                r_inner     <= INNER_FIRST + 10'sd1;
                r_drain_cnt <= 2'd0;
                r_en_p1     <= 1'b0;
                dv_o        <= 1'b0;
            end else if (w_issue) begin
                rd_en_o  <= 1'b1;
                rd_sel_o <= r_step;
                rd_px_o  <= r_step ? r_outer[7:0] : w_clamped;
                rd_py_o  <= r_step ? w_clamped : r_outer[7:0];
                r_step   <= w_step_nxt;
                r_outer  <= w_outer_nxt;
                r_inner  <= w_inner_nxt;
            end else begin
                rd_en_o <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_gauss_filter_imgrd.sv
// Bench for gauss_filter_imgrd: reduced 16x16 image, randomized hold and memory contents,
// full read sequence predicted from the nested scan loops.
module tb_gauss_filter_imgrd;

    localparam int IMG_W = 16;
    localparam int PAD   = 2;
    localparam int LINE  = IMG_W + 2 * PAD;
    localparam int TOTAL = 2 * IMG_W * LINE;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic       hold_i = 1'b0;
    logic       busy_o, finish, rd_en_o, rd_sel_o, dv_o;
    logic [7:0] rd_px_o, rd_py_o, dt_o;
    logic [7:0] rd_dt_i = 8'd0;

    int checks = 0;
    int failures = 0;
    int seed = 0;
    int exp_px[$];
    int exp_py[$];
    int exp_sel[$];

    always #5 clk = ~clk;

    gauss_filter_imgrd #(.IMG_W(IMG_W), .PAD(PAD)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .hold_i(hold_i),
        .busy_o(busy_o), .finish(finish), .rd_en_o(rd_en_o), .rd_sel_o(rd_sel_o),
        .rd_px_o(rd_px_o), .rd_py_o(rd_py_o), .rd_dt_i(rd_dt_i),
        .dt_o(dt_o), .dv_o(dv_o)
    );

    function automatic int clampf(input int v);
        if (v < 0) return 0;
        if (v > IMG_W - 1) return IMG_W - 1;
        return v;
    endfunction

    // With seed 0, row 0 of the source image holds its own column index.
    function automatic logic [7:0] memval(input int sel, input int px, input int py);
        return 8'((px + 31 * py + 97 * sel + seed) & 255);
    endfunction

    // One-cycle-latency memory; junk when not read.
    always @(posedge clk)
        rd_dt_i <= rd_en_o ? memval(int'(rd_sel_o), int'(rd_px_o), int'(rd_py_o)) : 8'($urandom);

    task automatic build_expected();
        for (int s = 0; s < 2; s++)
            for (int o = 0; o < IMG_W; o++)
                for (int i = -PAD; i <= IMG_W - 1 + PAD; i++) begin
                    exp_sel.push_back(s);
                    exp_px.push_back(s == 0 ? clampf(i) : o);
                    exp_py.push_back(s == 0 ? o : clampf(i));
                end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start = 1'b1; hold_i = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if ({busy_o, finish, rd_en_o, rd_sel_o, rd_px_o, rd_py_o, dt_o, dv_o} !== 28'd0) begin
            failures++;
            $display("FAIL reset_outputs got busy=%b fin=%b en=%b sel=%b px=%0d py=%0d dt=%0d dv=%b want all 0",
                     busy_o, finish, rd_en_o, rd_sel_o, rd_px_o, rd_py_o, dt_o, dv_o);
        end
        start = 1'b0; hold_i = 1'b0; rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (busy_o !== 1'b0 || rd_en_o !== 1'b0) begin
            failures++;
            $display("FAIL reset_priority got busy=%b en=%b want 0 0", busy_o, rd_en_o);
        end
    endtask

    // mode 0: no hold, 1: random hold, 2: one 5-cycle hold before read index 10
    task automatic test_full_scan(input int mode, input int sd);
        int nrd = 0, ndv = 0, nfin = 0, nbusy = 0, nheld = 0, cyc = 1, hold_left = 0;
        bit held_prev = 0, hold_done = 0;
        int rdcyc[$];
        seed = sd;
        start = 1'b1; hold_i = 1'b0;
        @(negedge clk);
        start = 1'b0;
        while (cyc < TOTAL * 4 + 100) begin
            if (busy_o) nbusy++;
            if (held_prev) begin
                checks++;
                if (rd_en_o !== 1'b0) begin
                    failures++;
                    $display("FAIL hold_gap cyc=%0d got rd_en=%b want 0", cyc, rd_en_o);
                end
            end
            if (rd_en_o) begin
                checks++;
                if (nrd >= TOTAL) begin
                    failures++;
                    $display("FAIL extra_read cyc=%0d got read %0d want at most %0d", cyc, nrd + 1, TOTAL);
                end else if ({rd_sel_o, rd_px_o, rd_py_o} !==
                             {1'(exp_sel[nrd]), 8'(exp_px[nrd]), 8'(exp_py[nrd])}) begin
                    failures++;
                    $display("FAIL read_coord idx=%0d got sel=%0d px=%0d py=%0d want sel=%0d px=%0d py=%0d",
                             nrd, rd_sel_o, rd_px_o, rd_py_o, exp_sel[nrd], exp_px[nrd], exp_py[nrd]);
                end
                rdcyc.push_back(cyc);
                nrd++;
            end
            if (dv_o) begin
                checks++;
                if (ndv >= rdcyc.size() || ndv >= TOTAL) begin
                    failures++;
                    $display("FAIL dv_unexpected cyc=%0d got dv idx=%0d want none", cyc, ndv);
                end else if (rdcyc[ndv] + 2 != cyc ||
                             dt_o !== memval(exp_sel[ndv], exp_px[ndv], exp_py[ndv])) begin
                    failures++;
                    $display("FAIL data_out idx=%0d got dt=%0d at cyc %0d want dt=%0d at cyc %0d",
                             ndv, dt_o, cyc, memval(exp_sel[ndv], exp_px[ndv], exp_py[ndv]), rdcyc[ndv] + 2);
                end
                ndv++;
            end
            if (finish) begin
                nfin++;
                checks++;
                if (!(dv_o && ndv == TOTAL)) begin
                    failures++;
                    $display("FAIL finish_time cyc=%0d got dv=%b ndv=%0d want dv=1 ndv=%0d", cyc, dv_o, ndv, TOTAL);
                end
            end
            if (!busy_o) break;
            case (mode)
                1: hold_i = ($urandom_range(0, 3) == 0);
                2: begin
                    if (nrd == 10 && !hold_done) begin hold_left = 5; hold_done = 1; end
                    hold_i = (hold_left > 0);
                    if (hold_left > 0) hold_left--;
                end
                default: hold_i = 1'b0;
            endcase
            held_prev = hold_i && (nrd < TOTAL);
            if (held_prev) nheld++;
            @(negedge clk);
            cyc++;
        end
        hold_i = 1'b0;
        checks++;
        if (busy_o !== 1'b0) begin
            failures++;
            $display("FAIL scan_timeout mode=%0d got busy=%b after %0d cycles want 0", mode, busy_o, cyc);
        end
        checks++;
        if (nrd != TOTAL || ndv != TOTAL) begin
            failures++;
            $display("FAIL counts mode=%0d got reads=%0d dv=%0d want %0d", mode, nrd, ndv, TOTAL);
        end
        checks++;
        if (nfin != 1) begin
            failures++;
            $display("FAIL finish_count mode=%0d got %0d want 1", mode, nfin);
        end
        checks++;
        if (nbusy != TOTAL + 2 + nheld) begin
            failures++;
            $display("FAIL busy_cycles mode=%0d got %0d want %0d", mode, nbusy, TOTAL + 2 + nheld);
        end
        if (mode == 2) begin
            checks++;
            if (nheld != 5) begin
                failures++;
                $display("FAIL hold_len got %0d want 5", nheld);
            end
        end
    endtask

    task automatic test_abort();
        int nfin = 0;
        bit found = 0;
        seed = int'($urandom_range(0, 255));
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int c = 0; c < TOTAL * 2; c++) begin
            if (finish) nfin++;
            if (rd_en_o && rd_sel_o && rd_px_o == 8'd3) begin
                found = 1;
                break;
            end
            @(negedge clk);
        end
        checks++;
        if (!found) begin
            failures++;
            $display("FAIL abort_point got not reached want step1 outer3 read");
        end
        checks++;
        if (nfin != 0) begin
            failures++;
            $display("FAIL abort_prefinish got %0d finish want 0", nfin);
        end
        test_full_scan(0, int'($urandom_range(0, 255)));
    endtask

    task automatic test_reset_mid();
        bit bad = 0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat ($urandom_range(50, 300)) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        checks++;
        if ({busy_o, finish, rd_en_o, rd_sel_o, rd_px_o, rd_py_o, dt_o, dv_o} !== 28'd0) begin
            failures++;
            $display("FAIL midreset_outputs got busy=%b fin=%b en=%b sel=%b px=%0d py=%0d dt=%0d dv=%b want all 0",
                     busy_o, finish, rd_en_o, rd_sel_o, rd_px_o, rd_py_o, dt_o, dv_o);
        end
        rst_n = 1'b1;
        repeat (5) begin
            @(negedge clk);
            if (finish || busy_o || dv_o || rd_en_o) bad = 1;
        end
        checks++;
        if (bad) begin
            failures++;
            $display("FAIL midreset_quiet got activity after reset want none");
        end
        test_full_scan(1, int'($urandom_range(0, 255)));
    endtask

    initial begin
        build_expected();
        test_reset();
        test_full_scan(0, 0);
        test_full_scan(1, int'($urandom_range(0, 255)));
        test_full_scan(2, int'($urandom_range(0, 255)));
        test_abort();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
